// File: rtl/pipe_int_ctrl_if.sv
// Control bundle between the pipeline sequencer and the CPU datapath.
// The master side is the sequencer: it reads hazard/status information
// and drives the stage-register enables, flushes and next-PC select.
interface pipe_int_ctrl_if;

  // Hazard and status information from decode / execute / memory
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_eret;
  logic       ex_memread;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       idex_valid;
  logic       mem_stall;
  logic       int_req;
  logic       int_en;

  // Stage-register and PC controls
  logic       pc_we;
  logic       ifid_we;
  logic       idex_we;
  logic       exmem_we;
  logic       memwb_we;
  logic       ifid_flush;
  logic       idex_flush;
  logic [1:0] pc_src;
  logic       epc_we;
  logic       epc_src;
  logic       int_ack;
  logic       in_isr;

  // Sequencer side
  modport master (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_eret,
           ex_memread, ex_rd, ex_branch_taken, idex_valid,
           mem_stall, int_req, int_en,
    output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, pc_src, epc_we, epc_src,
           int_ack, in_isr
  );

  // Datapath side
  modport slave (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_eret,
           ex_memread, ex_rd, ex_branch_taken, idex_valid,
           mem_stall, int_req, int_en,
    input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
           ifid_flush, idex_flush, pc_src, epc_we, epc_src,
           int_ack, in_isr
  );

endinterface

// File: rtl/pipe_int_ctrl.sv
// Pipeline sequencer for the 5-stage interrupt-capable CPU.
// Arbitrates memory stalls, branch redirects, load-use bubbles, interrupt
// entry (drain the back end, then vector) and ERET return. All controls are
// combinational from the registered sequencer state and the hazard inputs.
module pipe_int_ctrl #(
  // Unstalled cycles between interrupt acceptance and vectoring (1..15)
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  pipe_int_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_VECTOR
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,  // PC + 4
    PC_BRANCH = 2'b01,  // resolved branch/jump target
    PC_VECTOR = 2'b10,  // interrupt vector
    PC_EPC    = 2'b11   // return address saved at interrupt entry
  } pc_src_t;

  typedef struct packed {
    logic    pc_we;
    logic    ifid_we;
    logic    idex_we;
    logic    exmem_we;
    logic    memwb_we;
    logic    ifid_flush;
    logic    idex_flush;
    pc_src_t pc_src;
    logic    epc_we;
    logic    epc_src;
    logic    int_ack;
  } ctrl_t;

  // Free-running pipeline: every register advances, nothing is squashed.
  localparam ctrl_t CTRL_IDLE = '{
    pc_we:      1'b1,
    ifid_we:    1'b1,
    idex_we:    1'b1,
    exmem_we:   1'b1,
    memwb_we:   1'b1,
    ifid_flush: 1'b0,
    idex_flush: 1'b0,
    pc_src:     PC_SEQ,
    epc_we:     1'b0,
    epc_src:    1'b0,
    int_ack:    1'b0
  };

  // Whole pipeline frozen while data memory is not ready.
  localparam ctrl_t CTRL_FREEZE = '{
    pc_we:      1'b0,
    ifid_we:    1'b0,
    idex_we:    1'b0,
    exmem_we:   1'b0,
    memwb_we:   1'b0,
    ifid_flush: 1'b0,
    idex_flush: 1'b0,
    pc_src:     PC_SEQ,
    epc_we:     1'b0,
    epc_src:    1'b0,
    int_ack:    1'b0
  };

  // The counter counts down to zero, so DRAIN_CYCLES drain cycles need a
  // start value one lower.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       in_isr_q, in_isr_d;
  ctrl_t      ctrl;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic int_pending;
  logic eret_return;

  // Hazard and event decode for the instruction pair in ID / EX.
  // Register 0 is hardwired to zero, so a load targeting it never forwards
  // a real value and needs no bubble.
  assign rs_hit      = bus.id_uses_rs && (bus.id_rs == bus.ex_rd);
  assign rt_hit      = bus.id_uses_rt && (bus.id_rt == bus.ex_rd);
  assign load_use    = bus.ex_memread && (bus.ex_rd != 5'd0) && (rs_hit || rt_hit);
  assign int_pending = bus.int_req && bus.int_en && !in_isr_q;
  // ERET outside a handler has nothing to return to and is ignored.
  assign eret_return = bus.id_eret && in_isr_q;

  // Sequencer state register: FSM, drain counter and handler-active flag.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= 4'd0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_isr_q <= in_isr_d;
    end
  end

  // Next-state and control decode, highest priority first.
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves one unassigned and no latch can be inferred.
  always_comb begin
    ctrl     = CTRL_IDLE;
    state_d  = state_q;
    cnt_d    = cnt_q;
    in_isr_d = in_isr_q;

    if (bus.mem_stall) begin
      // Nothing moves, including the sequencer itself.
      ctrl = CTRL_FREEZE;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            // Redirect wins; a pending interrupt waits one cycle so the
            // saved EPC never names a wrong-path instruction.
            ctrl.pc_src     = PC_BRANCH;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (int_pending) begin
            // Save the oldest not-yet-executed instruction's PC: the one in
            // ID/EX if real, otherwise the one in IF/ID.
            ctrl.epc_we     = 1'b1;
            ctrl.epc_src    = !bus.idex_valid;
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            ctrl.pc_we      = 1'b0;
            cnt_d           = DRAIN_LOAD;
            state_d         = ST_DRAIN;
          end else if (eret_return) begin
            ctrl.pc_src     = PC_EPC;
            ctrl.ifid_flush = 1'b1;
            in_isr_d        = 1'b0;
          end else if (load_use) begin
            // Hold PC and IF/ID, insert a bubble into EX.
            ctrl.pc_we      = 1'b0;
            ctrl.ifid_we    = 1'b0;
            ctrl.idex_flush = 1'b1;
          end
        end

        ST_DRAIN: begin
          // Front end stays squashed while EX/MEM and MEM/WB retire.
          ctrl.pc_we      = 1'b0;
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = ST_VECTOR;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        ST_VECTOR: begin
          // Single cycle: load the vector, acknowledge, mask further entry.
          ctrl.pc_src     = PC_VECTOR;
          ctrl.pc_we      = 1'b1;
          ctrl.int_ack    = 1'b1;
          ctrl.ifid_flush = 1'b1;
          in_isr_d        = 1'b1;
          state_d         = ST_RUN;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Drive the bundle.
  assign bus.pc_we      = ctrl.pc_we;
  assign bus.ifid_we    = ctrl.ifid_we;
  assign bus.idex_we    = ctrl.idex_we;
  assign bus.exmem_we   = ctrl.exmem_we;
  assign bus.memwb_we   = ctrl.memwb_we;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.idex_flush = ctrl.idex_flush;
  assign bus.pc_src     = ctrl.pc_src;
  assign bus.epc_we     = ctrl.epc_we;
  assign bus.epc_src    = ctrl.epc_src;
  assign bus.int_ack    = ctrl.int_ack;
  assign bus.in_isr     = in_isr_q;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Self-checking bench for pipe_int_ctrl: a cycle-level behavioural model
// checked against the DUT every cycle, plus directed scenarios with
// hand-computed expectations at specific cycles.
module tb_pipe_int_ctrl;

  localparam int DRAIN = 2;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pipe_int_ctrl_if bus ();

  pipe_int_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // m_seq: -1 = running normally; N > 0 = N drain cycles still owed before
  // vectoring; 0 = this cycle is the vector cycle.
  int m_seq;
  bit m_isr;

  typedef struct {
    bit       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    bit       ifid_flush, idex_flush;
    bit [1:0] pc_src;
    bit       epc_we, epc_src, int_ack, in_isr;
  } exp_t;

  function automatic exp_t model_out();
    exp_t e;
    bit lu;
    e.pc_we = 1; e.ifid_we = 1; e.idex_we = 1; e.exmem_we = 1; e.memwb_we = 1;
    e.ifid_flush = 0; e.idex_flush = 0; e.pc_src = 2'b00;
    e.epc_we = 0; e.epc_src = 0; e.int_ack = 0; e.in_isr = m_isr;
    if (rst) begin
      e.in_isr = 0;
      return e;
    end
    if (bus.mem_stall) begin
      e.pc_we = 0; e.ifid_we = 0; e.idex_we = 0; e.exmem_we = 0; e.memwb_we = 0;
      return e;
    end
    if (m_seq > 0) begin
      e.pc_we = 0; e.ifid_flush = 1; e.idex_flush = 1;
      return e;
    end
    if (m_seq == 0) begin
      e.pc_src = 2'b10; e.int_ack = 1; e.ifid_flush = 1;
      return e;
    end
    lu = bus.ex_memread && bus.ex_rd != 0 &&
         ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
          (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
    if (bus.ex_branch_taken) begin
      e.pc_src = 2'b01; e.ifid_flush = 1; e.idex_flush = 1;
    end else if (bus.int_req && bus.int_en && !m_isr) begin
      e.epc_we = 1; e.epc_src = !bus.idex_valid;
      e.ifid_flush = 1; e.idex_flush = 1; e.pc_we = 0;
    end else if (bus.id_eret && m_isr) begin
      e.pc_src = 2'b11; e.ifid_flush = 1;
    end else if (lu) begin
      e.pc_we = 0; e.ifid_we = 0; e.idex_flush = 1;
    end
    return e;
  endfunction

  function automatic void model_step();
    if (rst) begin
      m_seq = -1; m_isr = 0;
    end else if (bus.mem_stall) begin
      // frozen
    end else if (m_seq > 0) begin
      m_seq = m_seq - 1;
    end else if (m_seq == 0) begin
      m_isr = 1; m_seq = -1;
    end else if (!bus.ex_branch_taken && bus.int_req && bus.int_en && !m_isr) begin
      m_seq = DRAIN;
    end else if (!bus.ex_branch_taken && bus.id_eret && m_isr) begin
      m_isr = 0;
    end
  endfunction

  bit done;

  // Compare process: outputs are sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!done) begin
      e = model_out();
      check("cmp_pc_we",      bus.pc_we,      e.pc_we);
      check("cmp_ifid_we",    bus.ifid_we,    e.ifid_we);
      check("cmp_idex_we",    bus.idex_we,    e.idex_we);
      check("cmp_exmem_we",   bus.exmem_we,   e.exmem_we);
      check("cmp_memwb_we",   bus.memwb_we,   e.memwb_we);
      check("cmp_ifid_flush", bus.ifid_flush, e.ifid_flush);
      check("cmp_idex_flush", bus.idex_flush, e.idex_flush);
      check("cmp_pc_src",     bus.pc_src,     e.pc_src);
      check("cmp_epc_we",     bus.epc_we,     e.epc_we);
      if (e.epc_we) check("cmp_epc_src", bus.epc_src, e.epc_src);
      check("cmp_int_ack",    bus.int_ack,    e.int_ack);
      check("cmp_in_isr",     bus.in_isr,     e.in_isr);
      model_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
    bus.id_eret = 0; bus.ex_memread = 0; bus.ex_rd = 0; bus.ex_branch_taken = 0;
    bus.idex_valid = 1; bus.mem_stall = 0; bus.int_req = 0; bus.int_en = 1;
  endtask

  // Wait to mid-cycle (after the compare process has sampled).
  task automatic apply();
    @(negedge clk); #1;
  endtask

  // Move just past the next rising edge, ready to drive new inputs.
  task automatic advance();
    @(posedge clk); #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; done = 0;
    m_seq = -1; m_isr = 0;
    rst = 1;
    set_idle();

    // ---- reset values ----
    apply();
    check("rst_pc_we",  bus.pc_we,  1);
    check("rst_in_isr", bus.in_isr, 0);
    check("rst_int_ack", bus.int_ack, 0);
    check("rst_pc_src", bus.pc_src, 0);
    advance();
    rst = 0;
    apply(); check("run_idle_pc_src", bus.pc_src, 0); advance();

    // ---- load-use on rs ----
    bus.ex_memread = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_uses_rs = 1;
    apply();
    check("lu_pc_we", bus.pc_we, 0);
    check("lu_ifid_we", bus.ifid_we, 0);
    check("lu_idex_flush", bus.idex_flush, 1);
    advance();
    // same pattern on r0: no stall
    bus.ex_rd = 0; bus.id_rs = 0;
    apply();
    check("lu_r0_pc_we", bus.pc_we, 1);
    check("lu_r0_idex_flush", bus.idex_flush, 0);
    advance();
    // load-use on rt
    bus.id_uses_rs = 0; bus.ex_rd = 7; bus.id_rt = 7; bus.id_uses_rt = 1;
    apply(); check("lu_rt_ifid_we", bus.ifid_we, 0); advance();
    // register match but rt not read
    bus.id_uses_rt = 0;
    apply(); check("lu_unused_pc_we", bus.pc_we, 1); advance();

    // ---- branch and load-use together ----
    bus.id_uses_rt = 1; bus.ex_branch_taken = 1;
    apply();
    check("br_pc_src", bus.pc_src, 2'b01);
    check("br_ifid_flush", bus.ifid_flush, 1);
    check("br_idex_flush", bus.idex_flush, 1);
    check("br_pc_we", bus.pc_we, 1);
    advance();

    // ---- ERET outside handler is a no-op ----
    set_idle(); bus.id_eret = 1;
    apply();
    check("eret_noisr_pc_src", bus.pc_src, 0);
    check("eret_noisr_flush", bus.ifid_flush, 0);
    advance();

    // ---- interrupt masked by int_en = 0 ----
    set_idle(); bus.int_en = 0; bus.int_req = 1;
    apply(); check("int_dis_epc_we", bus.epc_we, 0); advance();

    // ---- interrupt entry, ID/EX holds a bubble ----
    set_idle(); bus.idex_valid = 0; bus.int_req = 1;
    apply();                                         // T
    check("int_epc_we", bus.epc_we, 1);
    check("int_epc_src", bus.epc_src, 1);
    check("int_pc_we", bus.pc_we, 0);
    advance();
    bus.int_req = 0;                                 // drop: must not cancel
    for (int i = 1; i <= 2; i++) begin               // T+1, T+2
      apply();
      check("drain_pc_we", bus.pc_we, 0);
      check("drain_ifid_flush", bus.ifid_flush, 1);
      check("drain_exmem_we", bus.exmem_we, 1);
      check("drain_int_ack", bus.int_ack, 0);
      advance();
    end
    apply();                                         // T+3
    check("vec_int_ack", bus.int_ack, 1);
    check("vec_pc_src", bus.pc_src, 2'b10);
    check("vec_pc_we", bus.pc_we, 1);
    check("vec_in_isr_before", bus.in_isr, 0);
    advance();
    bus.int_req = 1;                                 // T+4: masked
    apply();
    check("isr_in_isr", bus.in_isr, 1);
    check("isr_masked_epc_we", bus.epc_we, 0);
    check("isr_masked_pc_we", bus.pc_we, 1);
    advance();
    apply(); check("isr_masked_ack", bus.int_ack, 0); advance();

    // ---- ERET return ----
    set_idle(); bus.id_eret = 1;
    apply();
    check("eret_pc_src", bus.pc_src, 2'b11);
    check("eret_ifid_flush", bus.ifid_flush, 1);
    advance();
    bus.id_eret = 0;
    apply(); check("eret_in_isr", bus.in_isr, 0); advance();

    // ---- interrupt and branch in the same cycle ----
    set_idle(); bus.int_req = 1; bus.ex_branch_taken = 1;
    apply();                                         // T
    check("intbr_pc_src", bus.pc_src, 2'b01);
    check("intbr_epc_we_T", bus.epc_we, 0);
    advance();
    bus.ex_branch_taken = 0;
    apply();                                         // T+1
    check("intbr_epc_we_T1", bus.epc_we, 1);
    check("intbr_epc_src", bus.epc_src, 0);
    advance();
    bus.int_req = 0;
    for (int i = 2; i <= 3; i++) begin
      apply(); check("intbr_no_ack_yet", bus.int_ack, 0); advance();
    end
    apply(); check("intbr_ack_T4", bus.int_ack, 1); advance();
    bus.id_eret = 1; apply(); check("intbr_eret", bus.pc_src, 2'b11); advance();

    // ---- mem_stall during DRAIN ----
    set_idle(); bus.int_req = 1;
    apply(); check("st_epc_we", bus.epc_we, 1); advance();      // T
    bus.int_req = 0;
    apply(); check("st_drain1", bus.pc_we, 0); advance();       // T+1
    bus.mem_stall = 1;
    for (int i = 2; i <= 4; i++) begin                           // T+2..T+4
      apply();
      check("st_pc_we", bus.pc_we, 0);
      check("st_ifid_we", bus.ifid_we, 0);
      check("st_exmem_we", bus.exmem_we, 0);
      check("st_memwb_we", bus.memwb_we, 0);
      check("st_flush", bus.ifid_flush, 0);
      check("st_int_ack", bus.int_ack, 0);
      advance();
    end
    bus.mem_stall = 0;
    apply(); check("st_drain2_ack", bus.int_ack, 0); advance(); // T+5
    apply(); check("st_ack_T6", bus.int_ack, 1); advance();     // T+6
    bus.id_eret = 1; apply(); check("st_eret", bus.pc_src, 2'b11); advance();

    // ---- reset pulse mid-DRAIN ----
    set_idle(); bus.int_req = 1;
    apply(); check("rd_epc_we", bus.epc_we, 1); advance();      // T
    bus.int_req = 0;
    apply(); check("rd_drain", bus.ifid_flush, 1); advance();   // T+1
    rst = 1;
    apply();                                                     // T+2
    check("rd_in_isr", bus.in_isr, 0);
    check("rd_int_ack", bus.int_ack, 0);
    check("rd_pc_we", bus.pc_we, 1);
    check("rd_ifid_flush", bus.ifid_flush, 0);
    rst = 0;
    advance();
    for (int i = 0; i < 4; i++) begin
      apply();
      check("rd_after_ack", bus.int_ack, 0);
      check("rd_after_pc_we", bus.pc_we, 1);
      advance();
    end

    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
